// File: rtl/tinyrisc_pkg.sv
// Shared TinyRISC definitions: opcode encodings, return-address register index
// and the branch-unit flush FSM state type.
package tinyrisc_pkg;

  localparam logic [4:0] OP_CMP  = 5'd5;
  localparam logic [4:0] OP_B    = 5'd16;
  localparam logic [4:0] OP_BEQ  = 5'd17;
  localparam logic [4:0] OP_BGT  = 5'd18;
  localparam logic [4:0] OP_CALL = 5'd19;
  localparam logic [4:0] OP_RET  = 5'd20;

  // Architectural register that receives the call return address.
  localparam logic [3:0] RA_INDEX = 4'd15;

  typedef enum logic [0:0] {
    IDLE,
    FLUSH
  } flush_state_e;

endpackage

// File: rtl/branch_cond.sv
// Branch condition decode (purely combinational).
// Ports:
//   opcode  - EX-stage opcode
//   flag_e  - current E flag (last cmp found operands equal)
//   flag_gt - current GT flag (last cmp found op1 > op2, signed)
//   taken   - opcode is a branch whose condition holds
//   is_ret  - opcode is ret (target comes from the ra operand)
//   is_call - opcode is call (return address must be written)
module branch_cond
  import tinyrisc_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic       flag_e,
  input  logic       flag_gt,
  output logic       taken,
  output logic       is_ret,
  output logic       is_call
);

  always_comb begin
    taken   = 1'b0;
    is_ret  = 1'b0;
    is_call = 1'b0;
    case (opcode)
      OP_B:    taken = 1'b1;
      OP_BEQ:  taken = flag_e;
      OP_BGT:  taken = flag_gt;
      OP_CALL: begin
        taken   = 1'b1;
        is_call = 1'b1;
      end
      OP_RET:  begin
        taken  = 1'b1;
        is_ret = 1'b1;
      end
      // Unknown opcodes behave as non-branches.
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Execute-stage branch resolver. Holds the E/GT flags register, resolves
// b/beq/bgt/call/ret, writes the call return address and squashes
// FLUSH_DEPTH younger wrong-path instructions after a taken branch.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   valid_in, opcode  - EX-stage instruction valid and opcode
//   pc_in             - PC of the EX-stage instruction
//   branchTarget      - precomputed PC-relative target
//   op1, op2          - operands (op1 is the ra value for ret)
//   branchPC          - registered target presented to fetch
//   isBranchTaken     - bit 0 is a one-cycle taken pulse, upper bits zero
//   flush             - squash younger instructions in IF/OF
//   ra_we, ra_data    - return-address write for call
//   flags_e, flags_gt - current flags (debug)
module branch_unit
  import tinyrisc_pkg::*;
#(
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter int unsigned XLEN        = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [4:0]      opcode,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] branchTarget,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] branchPC,
  output logic [XLEN-1:0] isBranchTaken,
  output logic            flush,
  output logic            ra_we,
  output logic [XLEN-1:0] ra_data,
  output logic            flags_e,
  output logic            flags_gt
);

  localparam int unsigned CntW = 3;

  flush_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            flag_e_q, flag_gt_q;
  logic            taken_q;
  logic            ra_we_q;
  logic [XLEN-1:0] branch_pc_q;
  logic [XLEN-1:0] ra_data_q;

  logic cond_taken, is_ret, is_call;
  logic accept, taken;

  branch_cond u_branch_cond (
    .opcode  (opcode),
    .flag_e  (flag_e_q),
    .flag_gt (flag_gt_q),
    .taken   (cond_taken),
    .is_ret  (is_ret),
    .is_call (is_call)
  );

  // Instructions arriving while squashing are wrong-path and must have no effect.
  assign accept = valid_in && (state_q == IDLE);
  assign taken  = accept && cond_taken;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (taken) begin
          state_d = FLUSH;
          cnt_d   = CntW'(FLUSH_DEPTH - 1);
        end
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: flush follows the registered state, so it rises together
  // with the taken pulse and lasts exactly FLUSH_DEPTH cycles.
  always_comb begin
    flush = (state_q == FLUSH);
  end

  // Flags and registered branch outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      flag_e_q    <= 1'b0;
      flag_gt_q   <= 1'b0;
      taken_q     <= 1'b0;
      ra_we_q     <= 1'b0;
      branch_pc_q <= '0;
      ra_data_q   <= '0;
    end else begin
      if (accept && (opcode == OP_CMP)) begin
        flag_e_q  <= (op1 == op2);
        flag_gt_q <= ($signed(op1) > $signed(op2));
      end
      taken_q <= taken;
      ra_we_q <= taken && is_call;
      if (taken) begin
        branch_pc_q <= is_ret ? op1 : branchTarget;
      end
      if (taken && is_call) begin
        ra_data_q <= pc_in + XLEN'(4);
      end
    end
  end

  assign branchPC      = branch_pc_q;
  assign isBranchTaken = {{(XLEN-1){1'b0}}, taken_q};
  assign ra_we         = ra_we_q;
  assign ra_data       = ra_data_q;
  assign flags_e       = flag_e_q;
  assign flags_gt      = flag_gt_q;

endmodule

// File: tb/tb_branch_unit.sv
module tb_branch_unit;
  import tinyrisc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [4:0]  opcode;
  logic [31:0] pc_in, branchTarget, op1, op2;
  logic [31:0] branchPC, isBranchTaken, ra_data;
  logic        flush, ra_we, flags_e, flags_gt;

  int n_checks = 0;
  int n_errors = 0;

  branch_unit #(
    .FLUSH_DEPTH (2),
    .XLEN        (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .valid_in      (valid_in),
    .opcode        (opcode),
    .pc_in         (pc_in),
    .branchTarget  (branchTarget),
    .op1           (op1),
    .op2           (op2),
    .branchPC      (branchPC),
    .isBranchTaken (isBranchTaken),
    .flush         (flush),
    .ra_we         (ra_we),
    .ra_data       (ra_data),
    .flags_e       (flags_e),
    .flags_gt      (flags_gt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic [31:0] a, input logic [31:0] b);
    valid_in = v; opcode = op; pc_in = pc; branchTarget = tgt; op1 = a; op2 = b;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    tick();
    check("rst_pc", branchPC, 32'h0);
    check("rst_taken", isBranchTaken, 32'h0);
    check("rst_flush", {31'b0, flush}, 32'h0);
    check("rst_rawe", {31'b0, ra_we}, 32'h0);
    check("rst_radata", ra_data, 32'h0);
    check("rst_flags", {30'b0, flags_e, flags_gt}, 32'h0);
    reset = 1'b0;

    // cmp equal then beq taken
    drive(1'b1, OP_CMP, 32'h0, 32'h0, 32'd5, 32'd5);
    tick();
    check("cmp55_flags", {30'b0, flags_e, flags_gt}, 32'h2);
    check("cmp55_taken", isBranchTaken, 32'h0);
    drive(1'b1, OP_BEQ, 32'h20, 32'h40, 32'h0, 32'h0);
    tick();
    check("beq_taken", isBranchTaken, 32'h1);
    check("beq_pc", branchPC, 32'h40);
    check("beq_flush1", {31'b0, flush}, 32'h1);
    idle();
    tick();
    check("beq_taken_pulse", isBranchTaken, 32'h0);
    check("beq_flush2", {31'b0, flush}, 32'h1);
    tick();
    check("beq_flush_end", {31'b0, flush}, 32'h0);

    // signed compare: -1 > 1 is false
    drive(1'b1, OP_CMP, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'd1);
    tick();
    check("cmpneg_flags", {30'b0, flags_e, flags_gt}, 32'h0);
    drive(1'b1, OP_BGT, 32'h30, 32'h80, 32'h0, 32'h0);
    tick();
    check("bgt_nt_taken", isBranchTaken, 32'h0);
    check("bgt_nt_flush", {31'b0, flush}, 32'h0);
    check("bgt_nt_pc_hold", branchPC, 32'h40);

    // 3 > -2 signed: GT set, bgt taken
    drive(1'b1, OP_CMP, 32'h0, 32'h0, 32'd3, 32'hFFFF_FFFE);
    tick();
    check("cmpgt_flags", {30'b0, flags_e, flags_gt}, 32'h1);
    drive(1'b1, OP_BGT, 32'h34, 32'h88, 32'h0, 32'h0);
    tick();
    check("bgt_t_taken", isBranchTaken, 32'h1);
    check("bgt_t_pc", branchPC, 32'h88);
    idle();
    tick();
    tick();

    // call then ret
    drive(1'b1, OP_CALL, 32'h100, 32'h200, 32'h0, 32'h0);
    tick();
    check("call_rawe", {31'b0, ra_we}, 32'h1);
    check("call_radata", ra_data, 32'h104);
    check("call_pc", branchPC, 32'h200);
    check("call_taken", isBranchTaken, 32'h1);
    idle();
    tick();
    check("call_rawe_pulse", {31'b0, ra_we}, 32'h0);
    tick();
    drive(1'b1, OP_RET, 32'h200, 32'h999, 32'h104, 32'h0);
    tick();
    check("ret_pc", branchPC, 32'h104);
    check("ret_taken", isBranchTaken, 32'h1);
    check("ret_rawe", {31'b0, ra_we}, 32'h0);
    idle();
    tick();
    tick();

    // b taken, cmps during flush are ignored (flags stay E=0,GT=1)
    drive(1'b1, OP_B, 32'h40, 32'h300, 32'h0, 32'h0);
    tick();
    check("b_taken", isBranchTaken, 32'h1);
    drive(1'b1, OP_CMP, 32'h0, 32'h0, 32'd7, 32'd7);
    tick();
    check("flush_cmp1_flags", {30'b0, flags_e, flags_gt}, 32'h1);
    check("flush_cmp1_flush", {31'b0, flush}, 32'h1);
    tick();
    check("flush_cmp2_flags", {30'b0, flags_e, flags_gt}, 32'h1);
    check("flush_cmp2_flush", {31'b0, flush}, 32'h0);
    tick();
    check("post_flush_cmp", {30'b0, flags_e, flags_gt}, 32'h2);

    // beq taken, then b presented during last flush cycle and right after
    drive(1'b1, OP_BEQ, 32'h50, 32'h500, 32'h0, 32'h0);
    tick();
    check("beq2_pc", branchPC, 32'h500);
    idle();
    tick();
    drive(1'b1, OP_B, 32'h60, 32'h600, 32'h0, 32'h0);
    tick();
    check("b_in_flush_taken", isBranchTaken, 32'h0);
    check("b_in_flush_flush", {31'b0, flush}, 32'h0);
    tick();
    check("b2b_taken", isBranchTaken, 32'h1);
    check("b2b_pc", branchPC, 32'h600);

    // reset in the first flush cycle
    idle();
    reset = 1'b1;
    tick();
    check("midrst_flush", {31'b0, flush}, 32'h0);
    check("midrst_flags", {30'b0, flags_e, flags_gt}, 32'h0);
    check("midrst_pc", branchPC, 32'h0);
    reset = 1'b0;
    drive(1'b1, OP_B, 32'h70, 32'h700, 32'h0, 32'h0);
    tick();
    check("postrst_taken", isBranchTaken, 32'h1);
    check("postrst_pc", branchPC, 32'h700);
    check("postrst_flush", {31'b0, flush}, 32'h1);
    idle();
    tick();
    tick();

    // call at top of address space wraps
    drive(1'b1, OP_CALL, 32'hFFFF_FFFC, 32'h10, 32'h0, 32'h0);
    tick();
    check("wrap_radata", ra_data, 32'h0);
    check("wrap_rawe", {31'b0, ra_we}, 32'h1);
    idle();
    tick();
    tick();

    // beq with E=0 not taken; unknown opcode not taken; b with E=GT=0 taken
    drive(1'b1, OP_BEQ, 32'h80, 32'h880, 32'h0, 32'h0);
    tick();
    check("beq_nt_taken", isBranchTaken, 32'h0);
    drive(1'b1, 5'd31, 32'h84, 32'h884, 32'h0, 32'h0);
    tick();
    check("unk_taken", isBranchTaken, 32'h0);
    check("unk_flush", {31'b0, flush}, 32'h0);
    drive(1'b1, OP_B, 32'h88, 32'h800, 32'h0, 32'h0);
    tick();
    check("b_noflags_taken", isBranchTaken, 32'h1);
    check("b_noflags_pc", branchPC, 32'h800);
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Execute-stage branch resolver. It produces the branch target and taken flag consumed by the fetch stage's next-PC mux.
- It holds the architectural flags register (E, GT), which cmp writes and beq/bgt read.
- It resolves b/beq/bgt/call/ret, writes the return address for call, and squashes wrong-path instructions through a flush FSM.
- It sits between the operand-fetch/EX pipeline register and instruction fetch.

Parameters:
- FLUSH_DEPTH, 2, number of younger wrong-path instructions squashed after a taken branch (1..7).
- XLEN, 32, datapath and PC width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  EX-stage instruction valid.
- opcode  in  5  EX-stage opcode.
- pc_in  in  XLEN  PC of the EX-stage instruction.
- branchTarget  in  XLEN  precomputed target, pc_in + (imm27 sign-extended << 2).
- op1  in  XLEN  first operand; for ret this is the ra value.
- op2  in  XLEN  second operand (cmp).
- branchPC  out  XLEN  target presented to fetch.
- isBranchTaken  out  XLEN  bit 0 = taken; bits 31:1 are always 0.
- flush  out  1  squash younger instructions in IF/OF.
- ra_we  out  1  write enable for the return address (register 15).
- ra_data  out  XLEN  return address value.
- flags_e  out  1  current E flag (debug).
- flags_gt  out  1  current GT flag (debug).

Behaviour:
- Reset (posedge clk with reset=1): branchPC=0, isBranchTaken=0, flush=0, ra_we=0, ra_data=0, E=0, GT=0, FSM=IDLE, flush counter=0. Reset mid-flush aborts the flush immediately.
- Accepted instruction = valid_in && FSM==IDLE. When FSM==FLUSH, valid_in is ignored: no flag update, no branch, no ra write.
- cmp (accepted):
  - E <= (op1 == op2).
  - GT <= ($signed(op1) > $signed(op2)).
  - The new flags are visible to the instruction accepted in the next cycle.
- Taken condition, for an accepted instruction: b or call or ret or (beq && E) or (bgt && GT). Evaluated against the flags register value before this edge.
- Outputs are registered, so there is 1 cycle of latency. For an instruction at posedge n:
  - branchPC and isBranchTaken are valid from posedge n until posedge n+1.
  - Fetch samples them on the negedge inside that window.
- branchPC <= (opcode==ret) ? op1 : branchTarget.
  - Updated only on taken; holds its last value otherwise.
  - isBranchTaken[0] is a 1-cycle pulse.
- call (accepted): ra_we pulses for 1 cycle together with isBranchTaken; ra_data <= pc_in + 4, with 32-bit wrap and carry discarded.
- Not-taken beq/bgt and non-branch opcodes: isBranchTaken=0, flush=0.
- FSM:
  - IDLE -> FLUSH on a taken branch; counter <= FLUSH_DEPTH-1.
  - flush=1 from the same cycle as isBranchTaken, for FLUSH_DEPTH consecutive cycles.
  - FLUSH: counter decrements each cycle; at 0 the FSM returns to IDLE and flush drops.
- Back-to-back: a branch arriving in the first cycle after flush drops is accepted normally.
- Unknown opcodes: treated as non-branch.

Decomposition:
- Shared package tinyrisc_pkg holds:
  - Opcode constants: OP_CMP=5'd5, OP_B=5'd16, OP_BEQ=5'd17, OP_BGT=5'd18, OP_CALL=5'd19, OP_RET=5'd20.
  - RA_INDEX=4'd15.
  - An FSM state enum {IDLE, FLUSH}.
- One natural sub-module, branch_cond: a combinational function of opcode, E, GT -> taken / is_ret / is_call. The flags register, output registers and FSM stay in branch_unit.

Test Plan:
- cmp op1=5, op2=5, then beq target 0x40 -> E=1, GT=0; next cycle isBranchTaken=1, branchPC=0x40, flush high for 2 cycles.
- cmp op1=-1 (0xFFFFFFFF), op2=1, then bgt -> GT=0 (signed compare); isBranchTaken stays 0 and flush stays 0.
- call at pc_in=0x100, target 0x200 -> ra_we=1, ra_data=0x104, branchPC=0x200 in the same cycle. Then ret with op1=0x104 -> branchPC=0x104.
- b taken, then two valid cmp (op1=op2) during the flush -> flags unchanged. A third instruction immediately after flush is accepted.
- reset asserted in the 1st flush cycle -> next cycle flush=0, E=GT=0, branchPC=0. A branch after reset deasserts resolves normally.
- call at pc_in=0xFFFFFFFC -> ra_data=0x00000000 (wrap). Unconditional b with E=GT=0 -> still taken.
